// File: rtl/mem_stream_pkg.sv
// Shared definitions for the ROM stream reader: FSM encoding, FIFO sizing and
// the issue-to-capture latency of the synchronous ROM path.
package mem_stream_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN} state_e;

  localparam int FIFO_DEPTH = 4;
  localparam int PIPE_LAT   = 2;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
endpackage

// File: rtl/byte_fifo.sv
// 4-entry synchronous FIFO carrying a data byte plus its last flag.
// Storage is cleared on reset so the head reads zero while empty.
module byte_fifo
  import mem_stream_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             empty
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [FIFO_DEPTH-1:0][WIDTH-1:0] mem;
  logic [PTR_W-1:0]                 wr_ptr, rd_ptr;
  logic                             do_pop;

  assign empty  = (count == '0);
  assign do_pop = pop && !empty;
  assign rdata  = mem[rd_ptr];

  // Upstream credit accounting guarantees push never hits a full FIFO.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(do_pop);
    end
  end
endmodule

// File: rtl/mem_stream_reader.sv
// Command-driven read sequencer for a synchronous ROM: issues one address per
// cycle under FIFO credit and streams the returned bytes on valid/ready.
module mem_stream_reader
  import mem_stream_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy
);
  localparam int AW = $clog2(DEPTH);

  state_e               state_q, state_d;
  logic [AW-1:0]        addr_q;
  logic [LEN_WIDTH-1:0] rem_q;
  logic [PIPE_LAT:1]    vld_pipe, last_pipe;
  logic                 issue, issue_last, load;
  logic [CNT_W-1:0]     fifo_cnt, inflight;
  logic [CNT_W:0]       occ;
  logic                 credit, fifo_empty, pop;
  logic [DATA_WIDTH:0]  fifo_rdata;
  logic                 unused_addr;

  assign unused_addr = ^cmd_addr[ADDR_WIDTH-1:AW];

  always_comb begin
    inflight = '0;
    for (int i = 1; i <= PIPE_LAT; i++) inflight = inflight + CNT_W'(vld_pipe[i]);
  end

  // A pop in the current cycle does not free credit until the next one.
  assign occ    = {1'b0, fifo_cnt} + {1'b0, inflight};
  assign credit = occ < (CNT_W+1)'(FIFO_DEPTH);
  assign pop    = out_valid && out_ready;

  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    issue_last = 1'b0;
    load       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // The accept cycle also issues the first address, so it shows at T+1.
        if (cmd_valid && cmd_len != '0) begin
          load       = 1'b1;
          issue      = 1'b1;
          issue_last = (cmd_len == LEN_WIDTH'(1));
          state_d    = issue_last ? ST_DRAIN : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (rem_q != '0 && credit) begin
          issue      = 1'b1;
          issue_last = (rem_q == LEN_WIDTH'(1));
          if (issue_last) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && out_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        addr_q <= cmd_addr[AW-1:0];
        rem_q  <= cmd_len - LEN_WIDTH'(1);
      end else if (issue) begin
        addr_q <= addr_q + 1'b1;
        rem_q  <= rem_q - LEN_WIDTH'(1);
      end
      vld_pipe  <= {vld_pipe[PIPE_LAT-1:1], issue};
      last_pipe <= {last_pipe[PIPE_LAT-1:1], issue_last};
    end
  end

  byte_fifo #(.WIDTH(DATA_WIDTH + 1)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (vld_pipe[PIPE_LAT]),
    .wdata   ({last_pipe[PIPE_LAT], read_data}),
    .pop     (pop),
    .rdata   (fifo_rdata),
    .count   (fifo_cnt),
    .empty   (fifo_empty)
  );

  assign read_addr = ADDR_WIDTH'(addr_q);
  assign out_valid = !fifo_empty;
  assign out_data  = fifo_rdata[DATA_WIDTH-1:0];
  assign out_last  = fifo_rdata[DATA_WIDTH];
  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = !cmd_ready;
endmodule

// File: tb/tb_mem_stream_reader.sv
// Scoreboard bench for mem_stream_reader with a behavioural ROM and a
// byte-list reference model; directed plan cases followed by random commands.
module tb_mem_stream_reader;
  localparam int AW = 16, DW = 8, DEPTH = 16, LW = 8;

  logic          clock = 1'b0, reset_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [AW-1:0] read_addr;
  logic [DW-1:0] read_data = '0;
  logic          out_valid, out_ready = 1'b1, out_last, busy;
  logic [DW-1:0] out_data;

  mem_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .LEN_WIDTH(LW)) dut (
    .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .read_addr(read_addr), .read_data(read_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy)
  );

  always #5 clock = ~clock;

  logic [7:0] rom [DEPTH] = '{8'h05, 8'h0A, 8'h08, 8'h04, 8'h02, 8'h01, 8'h03, 8'h06,
                              8'h10, 8'h10, 8'h3C, 8'h7E, 8'hA5, 8'hC3, 8'h10, 8'h1F};

  always @(posedge clock) read_data <= rom[read_addr[3:0]];

  typedef struct packed { logic [7:0] d; logic last; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0, failures = 0, pops = 0;
  bit   rdy_rand = 1'b0, rdy_val = 1'b1;
  logic hold_v = 1'b0;
  logic [8:0] hold_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference: a command is just the byte list rom[(addr+i) mod DEPTH].
  task automatic model_cmd(input int a, input int l);
    for (int i = 0; i < l; i++)
      exp_q.push_back('{d: rom[(a + i) % DEPTH], last: (i == l - 1)});
  endtask

  initial forever begin
    @(posedge clock); #1;
    out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;
  end

  always @(negedge clock) begin
    if (!reset_n) hold_v = 1'b0;
    else begin
      if (hold_v) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", {out_last, out_data}, hold_d);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_output actual=0x%0h expected=none", out_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_data", out_data, mon_e.d);
          chk("out_last", out_last, mon_e.last);
        end
        pops++;
      end
      hold_v = out_valid && !out_ready;
      hold_d = {out_last, out_data};
      chk("fifo_overflow", dut.fifo_cnt <= 3'd4, 1);
    end
  end

  // Returns just after the accepting edge (inside cycle T+1).
  task automatic send_cmd(input int a, input int l);
    int n = 0;
    @(negedge clock);
    cmd_valid = 1'b1; cmd_addr = AW'(a); cmd_len = LW'(l);
    while (!cmd_ready && n < 2000) begin @(negedge clock); n++; end
    if (n >= 2000) begin checks++; failures++; $display("FAIL cmd_accept_timeout actual=busy expected=ready"); end
    chk("accept_after_drain", exp_q.size(), 0);
    model_cmd(a, l);
    @(posedge clock); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 2000) begin @(negedge clock); n++; end
    if (n >= 2000) begin checks++; failures++; $display("FAIL idle_timeout actual=busy expected=idle"); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with a command offered: nothing must be accepted.
    cmd_valid = 1'b1; cmd_addr = 16'd3; cmd_len = 8'd5;
    repeat (3) @(negedge clock);
    chk("rst_read_addr", read_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    cmd_valid = 1'b0;
    reset_n   = 1'b1;
    @(negedge clock);
    chk("post_rst_busy", busy, 0);

    // addr 0 len 4, free-flowing output
    send_cmd(0, 4);
    @(negedge clock); chk("a_T1_read_addr", read_addr, 0); chk("a_T1_valid", out_valid, 0);
    @(negedge clock); chk("a_T2_valid", out_valid, 0);
    @(negedge clock); chk("a_T3_valid", out_valid, 1); chk("a_T3_data", out_data, 8'h05);
    @(negedge clock); chk("a_T4_last", out_last, 0);
    @(negedge clock);
    @(negedge clock); chk("a_T6_valid", out_valid, 1); chk("a_T6_last", out_last, 1);
    chk("a_T6_busy", busy, 1);
    @(negedge clock); chk("a_done_busy", busy, 0);
    wait_idle();

    // wrap: addr 14 len 3
    send_cmd(14, 3);
    @(negedge clock); chk("b_addr0", read_addr, 14);
    @(negedge clock); chk("b_addr1", read_addr, 15);
    @(negedge clock); chk("b_addr2", read_addr, 0);
    wait_idle();

    // backpressure: addr 0 len 8, consumer stalled through T+8
    rdy_val = 1'b0;
    send_cmd(0, 8);
    repeat (8) @(negedge clock);
    chk("c_stall_read_addr", read_addr, 3);
    chk("c_stall_valid", out_valid, 1);
    chk("c_stall_data", out_data, 8'h05);
    rdy_val = 1'b1;
    wait_idle();

    // zero length, then a command offered while busy
    send_cmd(5, 0);
    @(negedge clock); chk("d_len0_busy", busy, 0); chk("d_len0_ready", cmd_ready, 1);
    for (int i = 0; i < 4; i++) begin @(negedge clock); chk("d_len0_valid", out_valid, 0); end
    send_cmd(0, 4);
    @(negedge clock); cmd_valid = 1'b1; cmd_addr = 16'd2; cmd_len = 8'd3;
    chk("d_busy_cmd_ready", cmd_ready, 0);
    send_cmd(2, 3);
    wait_idle();

    // reset mid-command after two bytes
    pops = 0;
    send_cmd(4, 6);
    for (int n = 0; pops < 2 && n < 200; n++) @(negedge clock);
    chk("e_two_pops", pops >= 2, 1);
    @(posedge clock); #2;
    reset_n = 1'b0;
    #1;
    chk("e_rst_read_addr", read_addr, 0);
    chk("e_rst_valid", out_valid, 0);
    chk("e_rst_last", out_last, 0);
    chk("e_rst_data", out_data, 0);
    chk("e_rst_busy", busy, 0);
    chk("e_rst_ready", cmd_ready, 1);
    exp_q.delete();
    @(negedge clock); #1;
    reset_n = 1'b1;
    send_cmd(8, 2);
    wait_idle();

    // random commands with random backpressure
    rdy_rand = 1'b1;
    for (int k = 0; k < 40; k++) begin
      int a, l;
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 15));
      l = $urandom_range(0, 12);
      send_cmd(a, l);
      if (l > 0) begin
        @(negedge clock); chk("r_first_addr", read_addr, a % DEPTH);
      end
    end
    rdy_rand = 1'b0; rdy_val = 1'b1;
    wait_idle();
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
